// File: rtl/main_traffic_gen.sv
// Transmit-side packet source: emits a burst of {vc,dest,seq} words into the Main FIFO,
// rotating round-robin over the enabled classes and honouring full/almost-full backpressure.
module main_traffic_gen #(
   parameter int BW    = 6,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             start,
   input  logic [CNT_W-1:0] num_words,
   input  logic [3:0]       class_mask,
   input  logic             Main_full,
   input  logic             Main_almost_full,
   output logic             Main_wr,
   output logic [BW-1:0]    Main_data_in,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sent_count
);

   localparam int SEQ_W = BW - 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_HOLD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] num_q;
   logic [3:0]       mask_q;
   logic [1:0]       rr_ptr;
   logic [SEQ_W-1:0] seq_q [4];
   logic [1:0]       cls;
   logic [1:0]       idx;
   logic             stall;
   logic             last_word;
   logic             empty_burst;
   logic             write_en;

   assign stall       = Main_full | Main_almost_full;
   assign empty_burst = (num_words == '0) || (class_mask == '0);
   assign last_word   = (sent_count == num_q - CNT_W'(1));
   assign write_en    = (state == S_SEND) && !stall;

   // First enabled class at or after rr_ptr; descending scan lets the nearest offset win.
   always_comb begin
      cls = rr_ptr;
      idx = rr_ptr;
      for (int i = 3; i >= 0; i--) begin
         idx = rr_ptr + 2'(i);
         if (mask_q[idx]) cls = idx;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset_L) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = empty_burst ? S_DONE : S_SEND;
         S_SEND: begin
            if (stall)          state_nxt = S_HOLD;
            else if (last_word) state_nxt = S_DONE;
         end
         S_HOLD: if (!stall) state_nxt = S_SEND;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Moore outputs
   always_comb begin
      busy = (state == S_SEND) || (state == S_HOLD);
      done = (state == S_DONE);
   end

   // Datapath: burst config, registered FIFO write, per-class sequence numbers
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         Main_wr      <= 1'b0;
         Main_data_in <= '0;
         sent_count   <= '0;
         num_q        <= '0;
         mask_q       <= '0;
         rr_ptr       <= '0;
         for (int i = 0; i < 4; i++) seq_q[i] <= '0;
      end else begin
         Main_wr <= 1'b0;
         if (state == S_IDLE && start) begin
            num_q      <= num_words;
            mask_q     <= class_mask;
            sent_count <= '0;
         end
         if (write_en) begin
            Main_wr      <= 1'b1;
            Main_data_in <= {cls, seq_q[cls]};
            seq_q[cls]   <= seq_q[cls] + SEQ_W'(1);
            rr_ptr       <= cls + 2'd1;
            sent_count   <= sent_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_main_traffic_gen.sv
// Directed bench for main_traffic_gen: hand-computed word sequences checked per scenario.
module tb_main_traffic_gen;

   logic       clk = 1'b0;
   logic       reset_L = 1'b0;
   logic       start = 1'b0;
   logic [7:0] num_words = '0;
   logic [3:0] class_mask = '0;
   logic       Main_full = 1'b0;
   logic       Main_almost_full = 1'b0;
   logic       Main_wr;
   logic [5:0] Main_data_in;
   logic       busy;
   logic       done;
   logic [7:0] sent_count;

   int vectors = 0;
   int miscompares = 0;
   int done_cnt = 0;
   int viol_cnt = 0;
   logic [5:0] got_q [$];
   logic full_at_edge;

   main_traffic_gen #(.BW(6), .CNT_W(8)) dut (
      .clk(clk), .reset_L(reset_L), .start(start), .num_words(num_words),
      .class_mask(class_mask), .Main_full(Main_full), .Main_almost_full(Main_almost_full),
      .Main_wr(Main_wr), .Main_data_in(Main_data_in), .busy(busy), .done(done),
      .sent_count(sent_count)
   );

   always #5 clk = ~clk;

   // Write/done monitor: inputs change on negedge, so Main_full is stable at posedge.
   always @(posedge clk) begin
      full_at_edge = Main_full;
      #1;
      if (Main_wr) begin
         got_q.push_back(Main_data_in);
         if (full_at_edge) viol_cnt++;
      end
      if (done) done_cnt++;
   end

   task automatic do_reset();
      @(negedge clk);
      reset_L = 1'b0; start = 1'b0; Main_full = 1'b0; Main_almost_full = 1'b0;
      repeat (3) @(negedge clk);
      reset_L = 1'b1;
      got_q.delete();
   endtask

   // Returns at the negedge after the sampling edge; config inputs are then scrambled.
   task automatic pulse_start(input logic [7:0] n, input logic [3:0] m);
      @(negedge clk);
      start = 1'b1; num_words = n; class_mask = m;
      @(negedge clk);
      start = 1'b0; num_words = 8'd3; class_mask = 4'b0001;
   endtask

   task automatic wait_done(input string name);
      bit seen = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         if (done) seen = 1;
         else @(negedge clk);
      end
      if (!seen) begin
         $display("FAIL %s: done timeout, got=0 want=1", name);
         miscompares++;
      end
      vectors++;
      @(negedge clk);
   endtask

   task automatic check_words(input string name, input logic [5:0] exp_q [$]);
      if (got_q.size() !== exp_q.size()) begin
         $display("FAIL %s: word count got=%0d want=%0d", name, got_q.size(), exp_q.size());
         miscompares++;
      end
      vectors++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         if (got_q[i] !== exp_q[i]) begin
            $display("FAIL %s: word %0d got=%h want=%h", name, i, got_q[i], exp_q[i]);
            miscompares++;
         end
         vectors++;
      end
   endtask

   task automatic test_reset();
      reset_L = 1'b0; start = 1'b1; num_words = 8'd5; class_mask = 4'hF;
      repeat (3) @(negedge clk);
      start = 1'b0; reset_L = 1'b1;
      repeat (3) @(negedge clk);
      if ({Main_wr, Main_data_in, busy, done, sent_count} !== 17'd0) begin
         $display("FAIL reset: outputs got wr=%b data=%h busy=%b done=%b cnt=%0d want all 0",
                  Main_wr, Main_data_in, busy, done, sent_count);
         miscompares++;
      end
      vectors++;
      if (got_q.size() !== 0 || done_cnt !== 0) begin
         $display("FAIL reset_start: writes=%0d dones=%0d want 0/0", got_q.size(), done_cnt);
         miscompares++;
      end
      vectors++;
   endtask

   task automatic test_all_classes();
      logic [5:0] exp_q [$] = '{6'h00, 6'h10, 6'h20, 6'h30, 6'h01, 6'h11, 6'h21, 6'h31};
      int d0;
      do_reset();
      d0 = done_cnt;
      pulse_start(8'd8, 4'b1111);
      if (Main_wr !== 1'b0) begin
         $display("FAIL all_latency: early wr got=%b want=0", Main_wr);
         miscompares++;
      end
      vectors++;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (Main_wr !== 1'b1 || Main_data_in !== exp_q[i]) begin
            $display("FAIL all_word%0d: wr=%b data=%h want wr=1 data=%h", i, Main_wr, Main_data_in, exp_q[i]);
            miscompares++;
         end
         vectors++;
      end
      if (done !== 1'b1) begin
         $display("FAIL all_done: got=%b want=1", done);
         miscompares++;
      end
      vectors++;
      repeat (2) @(negedge clk);
      if (Main_wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sent_count !== 8'd8) begin
         $display("FAIL all_end: wr=%b busy=%b done=%b cnt=%0d want 0/0/0/8", Main_wr, busy, done, sent_count);
         miscompares++;
      end
      vectors++;
      if (done_cnt - d0 !== 1) begin
         $display("FAIL all_done_cnt: got=%0d want=1", done_cnt - d0);
         miscompares++;
      end
      vectors++;
   endtask

   task automatic test_single_class_wrap();
      logic [5:0] exp_q [$];
      int d0;
      for (int i = 0; i < 16; i++) exp_q.push_back(6'h20 + 6'(i));
      for (int i = 0; i < 4; i++)  exp_q.push_back(6'h20 + 6'(i));
      do_reset();
      d0 = done_cnt;
      pulse_start(8'd20, 4'b0100);
      repeat (5) @(negedge clk);
      pulse_start(8'd3, 4'b0001);
      wait_done("wrap");
      check_words("wrap", exp_q);
      if (sent_count !== 8'd20 || done_cnt - d0 !== 1) begin
         $display("FAIL wrap_end: cnt=%0d dones=%0d want 20/1", sent_count, done_cnt - d0);
         miscompares++;
      end
      vectors++;
   endtask

   task automatic test_almost_full();
      logic [5:0] exp_q [$] = '{6'h00, 6'h10, 6'h01, 6'h11, 6'h02, 6'h12, 6'h03, 6'h13, 6'h04, 6'h14};
      int c0, c1;
      bit busy_bad = 0, wr_bad = 0, seen = 0;
      do_reset();
      pulse_start(8'd10, 4'b0011);
      for (int i = 0; i < 50 && !seen; i++) begin
         if (got_q.size() >= 3) seen = 1;
         else @(negedge clk);
      end
      if (!seen) begin
         $display("FAIL af_wait3: got=%0d writes want=3", got_q.size());
         miscompares++;
      end
      vectors++;
      Main_almost_full = 1'b1;
      c0 = got_q.size();
      c1 = c0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) c1 = got_q.size();
         else if (got_q.size() != c1) wr_bad = 1;
         if (busy !== 1'b1) busy_bad = 1;
      end
      if (c1 > c0 + 1 || wr_bad || busy_bad) begin
         $display("FAIL af_hold: extra=%0d wr_bad=%b busy_bad=%b want <=1/0/0", c1 - c0, wr_bad, busy_bad);
         miscompares++;
      end
      vectors++;
      Main_almost_full = 1'b0;
      @(negedge clk);
      if (got_q.size() !== c1) begin
         $display("FAIL af_resume_gap: got=%0d want=%0d", got_q.size(), c1);
         miscompares++;
      end
      vectors++;
      @(negedge clk);
      if (got_q.size() !== c1 + 1) begin
         $display("FAIL af_resume: got=%0d want=%0d", got_q.size(), c1 + 1);
         miscompares++;
      end
      vectors++;
      wait_done("af");
      check_words("af", exp_q);
   endtask

   task automatic test_full_at_start();
      logic [5:0] exp_q [$] = '{6'h00, 6'h10, 6'h20, 6'h30};
      do_reset();
      Main_full = 1'b1;
      pulse_start(8'd4, 4'b1111);
      repeat (6) @(negedge clk);
      if (got_q.size() !== 0 || busy !== 1'b1) begin
         $display("FAIL full_block: writes=%0d busy=%b want 0/1", got_q.size(), busy);
         miscompares++;
      end
      vectors++;
      Main_full = 1'b0;
      wait_done("full");
      check_words("full", exp_q);
      if (sent_count !== 8'd4) begin
         $display("FAIL full_cnt: got=%0d want=4", sent_count);
         miscompares++;
      end
      vectors++;
   endtask

   task automatic test_empty_and_abort();
      int d0;
      do_reset();
      pulse_start(8'd0, 4'b1111);
      if (done !== 1'b1) begin
         $display("FAIL zero_words_done: got=%b want=1", done);
         miscompares++;
      end
      vectors++;
      pulse_start(8'd5, 4'b0000);
      if (done !== 1'b1) begin
         $display("FAIL zero_mask_done: got=%b want=1", done);
         miscompares++;
      end
      vectors++;
      @(negedge clk);
      if (got_q.size() !== 0 || done !== 1'b0 || sent_count !== 8'd0) begin
         $display("FAIL empty_writes: writes=%0d done=%b cnt=%0d want 0/0/0", got_q.size(), done, sent_count);
         miscompares++;
      end
      vectors++;
      pulse_start(8'd20, 4'b1111);
      repeat (3) @(negedge clk);
      d0 = done_cnt;
      reset_L = 1'b0;
      @(negedge clk);
      if (Main_wr !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL abort: wr=%b busy=%b want 0/0", Main_wr, busy);
         miscompares++;
      end
      vectors++;
      reset_L = 1'b1;
      repeat (3) @(negedge clk);
      if (done_cnt !== d0) begin
         $display("FAIL abort_done: pulses got=%0d want=0", done_cnt - d0);
         miscompares++;
      end
      vectors++;
   endtask

   initial begin
      test_reset();
      test_all_classes();
      test_single_class_wrap();
      test_almost_full();
      test_full_at_start();
      test_empty_and_abort();
      if (viol_cnt !== 0) begin
         $display("FAIL write_while_full: got=%0d want=0", viol_cnt);
         miscompares++;
      end
      vectors++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
